// File: rtl/gate16_arbiter.sv
// Two-port round-robin front end for a shared NOT/AND/OR/XOR logic unit.
// Ports: clk, reset (sync, active-high); req0_*/req1_* valid/ready command
//        ports (op, a, b); resp_valid/resp_ready/resp_data/resp_id result
//        port; op_count = results consumed since reset (wrapping).
module gate16_arbiter #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [1:0]           req0_op,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [1:0]           req1_op,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [WIDTH-1:0]     resp_data,
    output logic                 resp_id,
    output logic [CNT_WIDTH-1:0] op_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [1:0] OP_NOT = 2'd0;
    localparam logic [1:0] OP_AND = 2'd1;
    localparam logic [1:0] OP_OR  = 2'd2;
    localparam logic [1:0] OP_XOR = 2'd3;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     resp_data_q, resp_data_d;
    logic                 resp_id_q, resp_id_d;
    logic                 last_grant_q, last_grant_d;
    logic [CNT_WIDTH-1:0] op_count_q, op_count_d;

    logic             can_accept;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             consume;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] gate_out;

    function automatic logic [WIDTH-1:0] gate_op(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        unique case (op)
            OP_NOT:  r = ~a;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // The result slot can take a new command when it is empty, or when
    // its current occupant leaves this same cycle (no bubble).
    always_comb begin
        can_accept = !reset && ((state_q == EMPTY) || resp_ready);
        consume    = (state_q == FULL) && resp_ready;

        // On contention the requester that did not win last time goes.
        grant0 = can_accept && req0_valid &&
                 (!req1_valid || last_grant_q);
        grant1 = can_accept && req1_valid &&
                 (!req0_valid || !last_grant_q);
        accept = grant0 || grant1;

        sel_op   = grant1 ? req1_op : req0_op;
        sel_a    = grant1 ? req1_a  : req0_a;
        sel_b    = grant1 ? req1_b  : req0_b;
        gate_out = gate_op(sel_op, sel_a, sel_b);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        state_d      = state_q;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        last_grant_d = last_grant_q;
        op_count_d   = op_count_q;

        if (consume) begin
            op_count_d = op_count_q + CNT_WIDTH'(1);
        end

        if (accept) begin
            state_d      = FULL;
            resp_data_d  = gate_out;
            resp_id_d    = grant1;
            last_grant_d = grant1;
        end else if (consume) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= EMPTY;
            resp_data_q  <= '0;
            resp_id_q    <= 1'b0;
            last_grant_q <= 1'b1;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            last_grant_q <= last_grant_d;
            op_count_q   <= op_count_d;
        end
    end

    assign resp_valid = (state_q == FULL);
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign op_count   = op_count_q;

endmodule
